// File: rtl/evt_dp_sched_if.sv
// Handshake bundle between the event scheduler, the spike source and the neuron datapath.
// master = scheduler side (accepts spikes, issues datapath commands); slave = its environment.
interface evt_dp_sched_if #(
   parameter int ADDR_W = 8,
   parameter int EVT_W  = 32
);
   logic              spk_valid_i;
   logic              spk_ready_o;
   logic [EVT_W-1:0]  spk_data_i;

   logic              dp_valid_o;
   logic              dp_ready_i;
   logic [1:0]        dp_op_o;
   logic [ADDR_W-1:0] dp_addr_o;
   logic [EVT_W-1:0]  dp_data_o;

   modport master (
      input  spk_valid_i, spk_data_i, dp_ready_i,
      output spk_ready_o, dp_valid_o, dp_op_o, dp_addr_o, dp_data_o
   );

   modport slave (
      output spk_valid_i, spk_data_i, dp_ready_i,
      input  spk_ready_o, dp_valid_o, dp_op_o, dp_addr_o, dp_data_o
   );
endinterface

// File: rtl/evt_dp_sched.sv
// Arbitrates spikes against UPDATE/RST address sweeps onto one registered datapath command port.
// Spikes appear 1 cycle after acceptance; sweeps issue 1 cmd/cycle and stall in place when dp_ready_i is low.
module evt_dp_sched #(
   parameter int ADDR_W = 8,
   parameter int EVT_W  = 32,
   parameter int TS_W   = 32
) (
   input  logic              engine_clk_i,
   input  logic              engine_rst_i,
   input  logic              enable_i,
   input  logic [ADDR_W-1:0] sweep_len_i,
   input  logic [TS_W-1:0]   time_i,
   input  logic              time_tick_i,
   input  logic              rst_req_i,
   evt_dp_sched_if.master    bus,
   output logic              busy_o,
   output logic              sweep_done_o,
   output logic              tick_overrun_o
);
   localparam logic [1:0] OP_SPIKE  = 2'b00;
   localparam logic [1:0] OP_UPDATE = 2'b01;
   localparam logic [1:0] OP_RST    = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      UPD_SWEEP = 2'd1,
      RST_SWEEP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              pend_tick_q, pend_tick_d;
   logic              pend_rst_q, pend_rst_d;
   logic              overrun_q, overrun_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic              dp_valid_q, dp_valid_d;
   logic [1:0]        dp_op_q, dp_op_d;
   logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
   logic [EVT_W-1:0]  dp_data_q, dp_data_d;

   logic is_idle, out_free, dp_hs, start_rst, start_upd, spk_rdy, spk_hs;

   assign is_idle   = (state_q == IDLE);
   assign out_free  = !dp_valid_q || bus.dp_ready_i;
   assign dp_hs     = dp_valid_q && bus.dp_ready_i;
   assign start_rst = is_idle && enable_i && out_free && pend_rst_q;
   assign start_upd = is_idle && enable_i && out_free && !pend_rst_q && pend_tick_q;
   // Gated by reset so the port reads not-ready during every reset cycle.
   assign spk_rdy   = is_idle && enable_i && !pend_rst_q && !pend_tick_q && out_free && !engine_rst_i;
   assign spk_hs    = spk_rdy && bus.spk_valid_i;

   always_comb begin
      state_d     = state_q;
      pend_tick_d = pend_tick_q;
      pend_rst_d  = pend_rst_q;
      overrun_d   = overrun_q;
      done_d      = 1'b0;
      len_d       = len_q;
      cnt_d       = cnt_q;
      ts_d        = ts_q;
      dp_valid_d  = dp_valid_q;
      dp_op_d     = dp_op_q;
      dp_addr_d   = dp_addr_q;
      dp_data_d   = dp_data_q;

      // A request in the same cycle its flag clears re-arms the flag rather than counting as overrun.
      if (start_upd) pend_tick_d = 1'b0;
      if (start_rst) pend_rst_d  = 1'b0;
      if (time_tick_i) begin
         if (pend_tick_q && !start_upd) overrun_d = 1'b1;
         pend_tick_d = 1'b1;
      end
      if (rst_req_i) pend_rst_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (dp_hs) dp_valid_d = 1'b0;
            if (start_rst) begin
               state_d    = RST_SWEEP;
               len_d      = sweep_len_i;
               cnt_d      = '0;
               dp_valid_d = 1'b1;
               dp_op_d    = OP_RST;
               dp_addr_d  = '0;
               dp_data_d  = '0;
            end else if (start_upd) begin
               state_d    = UPD_SWEEP;
               len_d      = sweep_len_i;
               ts_d       = time_i;
               cnt_d      = '0;
               dp_valid_d = 1'b1;
               dp_op_d    = OP_UPDATE;
               dp_addr_d  = '0;
               dp_data_d  = EVT_W'(time_i);
            end else if (spk_hs) begin
               dp_valid_d = 1'b1;
               dp_op_d    = OP_SPIKE;
               dp_addr_d  = '0;
               dp_data_d  = bus.spk_data_i;
            end
         end
         UPD_SWEEP, RST_SWEEP: begin
            if (dp_hs) begin
               if (cnt_q == len_q) begin
                  state_d    = IDLE;
                  dp_valid_d = 1'b0;
                  done_d     = 1'b1;
                  cnt_d      = '0;
               end else begin
                  cnt_d     = cnt_q + 1'b1;
                  dp_addr_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge engine_clk_i) begin
      if (engine_rst_i) begin
         state_q     <= IDLE;
         pend_tick_q <= 1'b0;
         pend_rst_q  <= 1'b0;
         overrun_q   <= 1'b0;
         done_q      <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         ts_q        <= '0;
         dp_valid_q  <= 1'b0;
         dp_op_q     <= '0;
         dp_addr_q   <= '0;
         dp_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         pend_tick_q <= pend_tick_d;
         pend_rst_q  <= pend_rst_d;
         overrun_q   <= overrun_d;
         done_q      <= done_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         ts_q        <= ts_d;
         dp_valid_q  <= dp_valid_d;
         dp_op_q     <= dp_op_d;
         dp_addr_q   <= dp_addr_d;
         dp_data_q   <= dp_data_d;
      end
   end

   assign bus.spk_ready_o = spk_rdy;
   assign bus.dp_valid_o  = dp_valid_q;
   assign bus.dp_op_o     = dp_op_q;
   assign bus.dp_addr_o   = dp_addr_q;
   assign bus.dp_data_o   = dp_data_q;
   assign busy_o          = !is_idle;
   assign sweep_done_o    = done_q;
   assign tick_overrun_o  = overrun_q;
endmodule

// File: tb/tb_evt_dp_sched.sv
// Directed bench for evt_dp_sched: stimulus pushes expected commands, a forked monitor pops them on each dp handshake.
module tb_evt_dp_sched;
   localparam int ADDR_W = 8;
   localparam int EVT_W  = 32;
   localparam int TS_W   = 32;
   localparam logic [1:0] OP_SPK = 2'b00;
   localparam logic [1:0] OP_UPD = 2'b01;
   localparam logic [1:0] OP_RST = 2'b10;

   typedef struct packed {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [EVT_W-1:0]  data;
   } cmd_t;

   logic              engine_clk_i = 1'b0;
   logic              engine_rst_i;
   logic              enable_i;
   logic [ADDR_W-1:0] sweep_len_i;
   logic [TS_W-1:0]   time_i;
   logic              time_tick_i;
   logic              rst_req_i;
   logic              busy_o;
   logic              sweep_done_o;
   logic              tick_overrun_o;

   always #5 engine_clk_i = ~engine_clk_i;

   evt_dp_sched_if #(.ADDR_W(ADDR_W), .EVT_W(EVT_W)) bus ();

   evt_dp_sched #(.ADDR_W(ADDR_W), .EVT_W(EVT_W), .TS_W(TS_W)) dut (
      .engine_clk_i   (engine_clk_i),
      .engine_rst_i   (engine_rst_i),
      .enable_i       (enable_i),
      .sweep_len_i    (sweep_len_i),
      .time_i         (time_i),
      .time_tick_i    (time_tick_i),
      .rst_req_i      (rst_req_i),
      .bus            (bus),
      .busy_o         (busy_o),
      .sweep_done_o   (sweep_done_o),
      .tick_overrun_o (tick_overrun_o)
   );

   cmd_t exp_q[$];
   int   hs_cyc[$];
   int   cyc, checks, errors, done_cnt;
   cmd_t mon_cur, mon_prev, mon_exp;
   logic mon_stall;
   int   h0, d0;
   logic exp_rdy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge engine_clk_i);
      #1;
   endtask

   task automatic push_sweep(input logic [1:0] op, input int len, input logic [EVT_W-1:0] d);
      cmd_t c;
      for (int a = 0; a <= len; a++) begin
         c.op   = op;
         c.addr = ADDR_W'(a);
         c.data = d;
         exp_q.push_back(c);
      end
   endtask

   task automatic pulse_tick();
      time_tick_i = 1'b1;
      step();
      time_tick_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy_o || bus.dp_valid_o) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_in_time"}, 64'(n < budget), 64'd1);
      step();
   endtask

   task automatic wait_addr(input int addr, input int budget, input string name);
      int n = 0;
      while (!(bus.dp_valid_o && int'(bus.dp_addr_o) == addr) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_reached"}, 64'(n < budget), 64'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dp_valid"}, 64'(bus.dp_valid_o), 64'd0);
      chk({tag, "_spk_ready"}, 64'(bus.spk_ready_o), 64'd0);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_done"}, 64'(sweep_done_o), 64'd0);
      chk({tag, "_overrun"}, 64'(tick_overrun_o), 64'd0);
      chk({tag, "_op_addr_data"}, 64'({bus.dp_op_o, bus.dp_addr_o, bus.dp_data_o}), 64'd0);
   endtask

   initial begin
      engine_rst_i    = 1'b1;
      enable_i        = 1'b1;
      sweep_len_i     = '0;
      time_i          = '0;
      time_tick_i     = 1'b0;
      rst_req_i       = 1'b0;
      bus.spk_valid_i = 1'b0;
      bus.spk_data_i  = '0;
      bus.dp_ready_i  = 1'b1;
      mon_stall       = 1'b0;

      fork
         forever begin
            @(negedge engine_clk_i);
            cyc++;
            mon_cur = {bus.dp_op_o, bus.dp_addr_o, bus.dp_data_o};
            if (engine_rst_i) begin
               mon_stall = 1'b0;
            end else begin
               if (mon_stall) begin
                  chk("hold_valid", 64'(bus.dp_valid_o), 64'd1);
                  chk("hold_cmd", 64'(mon_cur), 64'(mon_prev));
               end
               if (sweep_done_o) done_cnt++;
               if (bus.dp_valid_o && bus.dp_ready_i) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_cmd: got 0x%0h expected none", mon_cur);
                  end else begin
                     mon_exp = exp_q.pop_front();
                     chk("dp_cmd", 64'(mon_cur), 64'(mon_exp));
                     hs_cyc.push_back(cyc);
                  end
               end
               mon_stall = bus.dp_valid_o && !bus.dp_ready_i;
               mon_prev  = mon_cur;
            end
         end
      join_none

      step();
      step();
      chk_reset_vals("rst_init");
      engine_rst_i = 1'b0;
      step();

      // Update sweep of 4 addresses with time 0x55
      sweep_len_i = 8'd3;
      time_i      = 32'h55;
      push_sweep(OP_UPD, 3, 32'h55);
      h0 = hs_cyc.size();
      d0 = done_cnt;
      pulse_tick();
      wait_idle(20, "upd4");
      chk("upd4_count", 64'(hs_cyc.size() - h0), 64'd4);
      if (hs_cyc.size() >= h0 + 4) chk("upd4_span", 64'(hs_cyc[h0+3] - hs_cyc[h0]), 64'd3);
      chk("upd4_done", 64'(done_cnt - d0), 64'd1);

      // RST sweep stalled 5 cycles at address 2
      sweep_len_i = 8'd4;
      push_sweep(OP_RST, 4, 32'h0);
      rst_req_i = 1'b1;
      step();
      rst_req_i = 1'b0;
      wait_addr(2, 20, "bp");
      bus.dp_ready_i = 1'b0;
      repeat (5) step();
      chk("bp_stall_cmd", 64'({bus.dp_valid_o, bus.dp_op_o, bus.dp_addr_o}), 64'({1'b1, OP_RST, 8'd2}));
      bus.dp_ready_i = 1'b1;
      wait_idle(20, "bp");

      // Continuous spikes with a tick at k=3: ready low k=4..7 while the 3-address sweep runs
      sweep_len_i     = 8'd2;
      time_i          = 32'h77;
      bus.spk_valid_i = 1'b1;
      bus.spk_data_i  = 32'h1000;
      for (int k = 0; k < 12; k++) begin
         time_tick_i = (k == 3);
         exp_rdy = !(k >= 4 && k <= 7);
         chk("spk_ready", 64'(bus.spk_ready_o), 64'(exp_rdy));
         if (exp_rdy) exp_q.push_back({OP_SPK, 8'd0, bus.spk_data_i});
         if (k == 3) push_sweep(OP_UPD, 2, 32'h77);
         step();
         if (exp_rdy) bus.spk_data_i = bus.spk_data_i + 32'd1;
      end
      time_tick_i     = 1'b0;
      bus.spk_valid_i = 1'b0;
      wait_idle(20, "spk");

      // Tick+reset together, two more ticks during the RST sweep
      sweep_len_i = 8'd1;
      time_i      = 32'hA5A5_0001;
      push_sweep(OP_RST, 1, 32'h0);
      push_sweep(OP_UPD, 1, 32'hA5A5_0001);
      d0 = done_cnt;
      time_tick_i = 1'b1;
      rst_req_i   = 1'b1;
      step();
      time_tick_i = 1'b0;
      rst_req_i   = 1'b0;
      step();
      time_tick_i = 1'b1;
      step();
      step();
      time_tick_i = 1'b0;
      wait_idle(30, "simul");
      chk("simul_overrun", 64'(tick_overrun_o), 64'd1);
      chk("simul_done", 64'(done_cnt - d0), 64'd2);
      repeat (5) step();
      chk("simul_no_extra", 64'(busy_o), 64'd0);

      // Reset at address 5 of an 8-address sweep; a tick during reset is dropped
      sweep_len_i = 8'd7;
      time_i      = 32'h1234;
      push_sweep(OP_UPD, 4, 32'h1234);
      pulse_tick();
      wait_addr(5, 20, "midrst");
      engine_rst_i = 1'b1;
      step();
      chk_reset_vals("midrst");
      time_tick_i = 1'b1;
      step();
      time_tick_i  = 1'b0;
      engine_rst_i = 1'b0;
      repeat (4) step();
      chk("rst_tick_dropped", 64'({busy_o, bus.dp_valid_o}), 64'd0);
      chk("midrst_queue", 64'(exp_q.size()), 64'd0);
      sweep_len_i = 8'd1;
      time_i      = 32'h99;
      push_sweep(OP_UPD, 1, 32'h99);
      pulse_tick();
      wait_idle(20, "postrst");

      // Single-address sweep
      sweep_len_i = 8'd0;
      time_i      = 32'h0BAD;
      push_sweep(OP_UPD, 0, 32'h0BAD);
      d0 = done_cnt;
      pulse_tick();
      wait_idle(20, "len0");
      chk("len0_done", 64'(done_cnt - d0), 64'd1);

      // Pending tick held off by enable_i=0
      enable_i    = 1'b0;
      sweep_len_i = 8'd1;
      time_i      = 32'h4242;
      pulse_tick();
      repeat (5) step();
      chk("en_gate", 64'({busy_o, bus.dp_valid_o}), 64'd0);
      push_sweep(OP_UPD, 1, 32'h4242);
      enable_i = 1'b1;
      wait_idle(20, "en_gate");

      // Full address range, no wrap
      sweep_len_i = 8'hFF;
      time_i      = 32'hCAFE;
      push_sweep(OP_UPD, 255, 32'hCAFE);
      d0 = done_cnt;
      pulse_tick();
      wait_idle(400, "full");
      chk("full_done", 64'(done_cnt - d0), 64'd1);
      repeat (3) step();
      chk("final_queue", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
